// File: rtl/crossbar_shift_scheduler.sv
// Shift-based crossbar scheduler: each transfer picks one circular shift (round-robin) and grants
// every requesting input that shift routes correctly. Optional check: XBAR_SCHED_PROTO_CHECK_EN.
module crossbar_shift_scheduler #(
  parameter int unsigned N = 8,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N-1:0][W-1:0] req_dest,
  input  logic                out_ready,
  output logic [W-1:0]        shift,
  output logic                shift_valid,
  output logic [N-1:0]        grant,
  output logic                proto_error
);

  typedef enum logic [1:0] {StIdle, StArb, StXfer} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        ptr_q, ptr_d;
  logic [W-1:0]        shift_q, shift_d;
  logic                valid_q, valid_d;
  logic [N-1:0]        grant_q, grant_d;

  logic [N-1:0][W-1:0] need;
  logic [N-1:0]        hits;
  logic [W-1:0]        sel;
  logic [W-1:0]        cand;
  logic                found;
  logic [N-1:0]        sel_grant;
  logic                any_req;

  assign any_req = |req_valid;

  // Shift that carries input i to its destination: output j reads input (j + shift) mod N.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      need[i] = W'(i) - req_dest[i];
    end
  end

  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        hits[need[i]] = 1'b1;
      end
    end
  end

  // Round-robin search starting at ptr, wrapping naturally in W bits.
  always_comb begin
    sel   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr_q + W'(k);
      if (!found && hits[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      sel_grant[i] = req_valid[i] && (need[i] == sel);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    shift_d = shift_q;
    valid_d = valid_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (!any_req) begin
          state_d = StIdle;
        end else begin
          shift_d = sel;
          grant_d = sel_grant;
          valid_d = 1'b1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (out_ready) begin
          ptr_d   = shift_q + W'(1);
          grant_d = '0;
          valid_d = 1'b0;
          state_d = any_req ? StArb : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign shift       = shift_q;
  assign shift_valid = valid_q;
  assign grant       = grant_q;

`ifdef XBAR_SCHED_PROTO_CHECK_EN
  logic [N-1:0][W-1:0] dest_cap_q;
  logic                proto_q;
  logic                violation;

  // A granted requester must hold its request steady until the datapath accepts it.
  always_comb begin
    violation = 1'b0;
    if (state_q == StXfer && !out_ready) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (grant_q[i] && (!req_valid[i] || (req_dest[i] != dest_cap_q[i]))) begin
          violation = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_cap_q <= '0;
      proto_q    <= 1'b0;
    end else begin
      if (state_q == StArb) begin
        dest_cap_q <= req_dest;
      end
      if (violation) begin
        proto_q <= 1'b1;
      end
    end
  end

  assign proto_error = proto_q;
`else
  assign proto_error = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_shift_scheduler.sv
// Scoreboard bench for crossbar_shift_scheduler: directed scenarios plus randomized requesters.
module tb_crossbar_shift_scheduler;

  localparam int N = 8;
  localparam int W = 3;
`ifdef XBAR_SCHED_PROTO_CHECK_EN
  localparam logic PROTO_EN = 1'b1;
`else
  localparam logic PROTO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_dest;
  logic                out_ready;
  logic [W-1:0]        shift;
  logic                shift_valid;
  logic [N-1:0]        grant;
  logic                proto_error;

  crossbar_shift_scheduler #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dest   (req_dest),
    .out_ready  (out_ready),
    .shift      (shift),
    .shift_valid(shift_valid),
    .grant      (grant),
    .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  typedef struct packed {
    logic [W-1:0] shift;
    logic [N-1:0] grant;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  // Reference model: transaction-level view of the scheduler, using integer mod-N arithmetic.
  int m_phase;  // 0 waiting, 1 arbitrating, 2 transferring
  int m_ptr;
  int m_shift;
  int m_best;
  int m_s;
  exp_t m_e;

  function automatic int need_of(input int i, input int dest);
    return (i - dest + N) % N;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      m_shift = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (req_valid != '0) m_phase = 1;
        1: begin
          if (req_valid == '0) begin
            m_phase = 0;
          end else begin
            m_best = -1;
            for (int k = 0; k < N; k++) begin
              m_s = (m_ptr + k) % N;
              for (int i = 0; i < N; i++) begin
                if (m_best < 0 && req_valid[i] && need_of(i, int'(req_dest[i])) == m_s) m_best = m_s;
              end
            end
            m_e.shift = W'(m_best);
            m_e.grant = '0;
            for (int i = 0; i < N; i++) begin
              m_e.grant[i] = req_valid[i] && (need_of(i, int'(req_dest[i])) == m_best);
            end
            exp_q.push_back(m_e);
            m_shift = m_best;
            m_phase = 2;
          end
        end
        default: begin
          if (out_ready) begin
            m_ptr   = (m_shift + 1) % N;
            m_phase = (req_valid != '0) ? 1 : 0;
          end
        end
      endcase
    end
  end

  // Monitor: each new transfer pops one expectation; held transfers must stay unchanged.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (shift_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected transfer", 32'(shift_valid), 32'(1'b0));
        end else begin
          cur = exp_q.pop_front();
          check("sb shift", 32'(shift), 32'(cur.shift));
          check("sb grant", 32'(grant), 32'(cur.grant));
        end
      end else if (shift_valid) begin
        check("hold shift", 32'(shift), 32'(cur.shift));
        check("hold grant", 32'(grant), 32'(cur.grant));
      end else begin
        check("idle grant", 32'(grant), 32'(0));
      end
      prev_v = shift_valid;
    end
  end

  task automatic clr();
    req_valid = '0;
    req_dest  = '0;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [N-1:0] served;

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    check("reset shift", 32'(shift), 32'(0));
    check("reset valid", 32'(shift_valid), 32'(0));
    check("reset grant", 32'(grant), 32'(0));
    check("reset proto", 32'(proto_error), 32'(0));
    #1 rst = 1'b0;

    // No requests: stays idle.
    repeat (10) begin
      @(negedge clk);
      check("idle valid", 32'(shift_valid), 32'(0));
      check("idle shift", 32'(shift), 32'(0));
    end

    // Single request held through backpressure.
    req_valid = 8'h08;
    req_dest[3] = 3'd1;
    @(negedge clk);
    check("arb bubble", 32'(shift_valid), 32'(0));
    @(negedge clk);
    check("t2 shift", 32'(shift), 32'(2));
    check("t2 grant", 32'(grant), 32'h08);
    repeat (2) begin
      @(negedge clk);
      check("t2 held", 32'({shift_valid, shift, grant}), 32'({1'b1, 3'd2, 8'h08}));
    end
    out_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("t2 done valid", 32'(shift_valid), 32'(0));
    check("t2 done grant", 32'(grant), 32'(0));
    repeat (3) begin
      @(negedge clk);
      check("t2 idle", 32'({shift_valid, shift}), 32'({1'b0, 3'd2}));
    end

    // Full permutation: every input needs shift 3.
    req_valid = 8'hFF;
    for (int i = 0; i < N; i++) req_dest[i] = W'(i - 3);
    repeat (2) @(negedge clk);
    check("t3 shift", 32'(shift), 32'(3));
    check("t3 grant", 32'(grant), 32'hFF);
    req_valid = '0;
    @(negedge clk);
    check("t3 done", 32'(shift_valid), 32'(0));

    // Two inputs contend for output 0.
    pulse_reset();
    req_valid = 8'h03;
    req_dest  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4 first shift", 32'(shift), 32'(0));
    check("t4 first grant", 32'(grant), 32'h01);
    @(negedge clk);
    req_valid = 8'h02;
    @(negedge clk);
    check("t4 second shift", 32'(shift), 32'(1));
    check("t4 second grant", 32'(grant), 32'h02);
    req_valid = '0;
    @(negedge clk);

    // Round-robin alternation between shifts 0 and 4.
    pulse_reset();
    req_valid = 8'h21;
    req_dest[0] = 3'd0;
    req_dest[5] = 3'd1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      check("t5 shift", 32'(shift), (k % 2 == 1) ? 32'(4) : 32'(0));
      check("t5 grant", 32'(grant), (k % 2 == 1) ? 32'h20 : 32'h01);
    end

    // Asynchronous reset mid-transfer, then arbitration restarts from pointer 0.
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async valid", 32'(shift_valid), 32'(0));
    check("async grant", 32'(grant), 32'(0));
    check("async shift", 32'(shift), 32'(0));
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst shift", 32'(shift), 32'(0));
    check("post rst grant", 32'(grant), 32'h01);
    req_valid = '0;
    repeat (2) @(negedge clk);

    // Granted requester changes destination under backpressure.
    pulse_reset();
    clr();
    req_valid = 8'h04;
    req_dest[2] = 3'd5;
    repeat (2) @(negedge clk);
    check("proto clean", 32'(proto_error), 32'(0));
    check("proto grant", 32'(grant), 32'h04);
    req_dest[2] = 3'd6;
    @(negedge clk);
    check("proto set", 32'(proto_error), 32'(PROTO_EN));
    req_dest[2] = 3'd5;
    @(negedge clk);
    check("proto sticky", 32'(proto_error), 32'(PROTO_EN));
    pulse_reset();
    clr();
    check("proto cleared", 32'(proto_error), 32'(0));

    // Randomized well-behaved requesters with random backpressure.
    served = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (served[i]) begin
          if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
          else req_dest[i] = W'($urandom_range(0, N - 1));
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_dest[i]  = W'($urandom_range(0, N - 1));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      served = grant & {N{out_ready}};
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("queue drained", 32'(exp_q.size()), 32'(0));
    check("random valid", 32'(shift_valid), 32'(0));
    check("random proto", 32'(proto_error), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crossbar_shift_scheduler.md
# crossbar_shift_scheduler

- Arbitrates per-input transfer requests onto the barrel-shifter crossbar, which is configured by a single circular shift per transfer.
- Each transfer cycle it picks one shift value (round-robin over shift values) and grants every input whose destination that shift reaches.
- Grants are collision-free by construction.
- Sits between the input port queues and the crossbar datapath. It drives the datapath shift directly, replacing per-output `input_sel` decoding for scheduled traffic.

## Interface
- `N`, 8: number of ports, power of two ≥ 2. `W = $clog2(N)`.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in [N-1:0]: input i has a transfer pending.
- `req_dest` in [N-1:0][W-1:0]: destination output port of input i. Meaningful only when `req_valid[i]`=1.
- `out_ready` in 1: datapath accepts the current transfer this cycle.
- `shift` out W: registered shift to the barrel shifter; output j carries input (j+`shift`) mod N.
- `shift_valid` out 1: `shift`/`grant` describe a live transfer.
- `grant` out [N-1:0]: inputs served by the current transfer.
- `proto_error` out 1: sticky requester-protocol violation (see Configuration).

## Operation
- Input i needs shift `need_i = (i - req_dest[i]) mod N`, computed in W-bit wrap-around arithmetic.
- `hits[s]` = OR over valid i of (`need_i` == s).
- Inputs sharing a destination need distinct shifts, so they are never granted together.
- Round-robin pointer `ptr` (W bits).
- Selected shift = first s with `hits[s]`=1, searching `ptr`, `ptr`+1, … mod N.
- FSM states: IDLE, ARB, XFER.
- **IDLE**
  - `shift_valid`=0, `grant`=0.
  - If any `req_valid` → ARB, else stay.
- **ARB** (exactly one cycle)
  - If no `req_valid`: → IDLE, `ptr` unchanged.
  - Else: register `shift` = selected s and `grant[i]` = `req_valid[i]` & (`need_i`==s), set `shift_valid`=1, → XFER.
- **XFER**
  - `shift`, `grant`, `shift_valid` held constant while `out_ready`=0.
  - Request inputs are ignored in XFER, except by the protocol check.
  - On an edge with `out_ready`=1: transfer completes, `ptr` ← (`shift`+1) mod N, `grant`/`shift_valid` ← 0.
  - Next state after completion: ARB if any `req_valid` sampled that edge, else IDLE.
- Requester rule: an input with `grant[i]` & `out_ready` is served. It must deassert `req_valid[i]` or present its next destination in the following cycle.
- `shift` retains its last value when `shift_valid`=0.
- Reset values: state IDLE, `shift`=0, `shift_valid`=0, `grant`=0, `ptr`=0, `proto_error`=0.

## Timing
- Request to grant: `req_valid` sampled at edge k (IDLE→ARB). `shift`/`grant` valid after edge k+1.
- Back-to-back requests: completion at edge k (→ARB), next grant after edge k+1. There is one bubble cycle per transfer, so peak rate is one transfer per 2 cycles.
- Fairness: a continuously valid input is granted within N completed transfers.
- `rst` assertion mid-XFER clears all outputs immediately, independent of `clk`. The in-flight transfer is dropped.
- Deassertion is synchronized externally.

## Configuration
- Macro `XBAR_SCHED_PROTO_CHECK_EN`.
- Defined:
  - In XFER, while `out_ready`=0, `proto_error` sets if any granted input drops `req_valid[i]` or changes `req_dest[i]` relative to its value captured in ARB.
  - Sticky until `rst`.
  - Adds an N×W destination capture register.
- Undefined: no capture register, and `proto_error` is tied to 0.

## Test plan
- Reset, then `req_valid`=0 for 10 cycles → `shift_valid`=0, `grant`=0, `shift`=0 throughout.
- Input 3 `req_dest`=1, `out_ready`=0 for 3 cycles then 1 → after the second edge `shift`=2, `grant`=8'h08. Held 4 cycles, cleared the edge after `out_ready`=1, FSM returns to IDLE.
- All 8 inputs valid, `req_dest[i]`=(i-3) mod 8, `out_ready`=1 → single transfer with `shift`=3, `grant`=8'hFF.
- Inputs 0 and 1 both `req_dest`=0, each held valid until served, `out_ready`=1 → first `shift`=0 `grant`=8'h01, then `shift`=1 `grant`=8'h02. Never both granted.
- Input 0 `req_dest`=0 and input 5 `req_dest`=1, always valid, `out_ready`=1 → shifts alternate 0,4,0,4. `ptr` advances 1,5,1,5.
- `rst` pulsed mid-XFER → outputs 0 with no clock edge. The next arbitration starts from `ptr`=0. With `XBAR_SCHED_PROTO_CHECK_EN`, changing granted input's `req_dest` while `out_ready`=0 sets `proto_error`=1 until reset.
